// File: rtl/morse_digit_decoder_if.sv
// Keyed-line / decoded-digit bundle for morse_digit_decoder.
// master: the side that keys the line and consumes digits.
// slave : the decoder itself.
interface morse_digit_decoder_if;
   logic       key;
   logic [3:0] digit;
   logic [4:0] code;
   logic       valid;
   logic       error;
   logic       busy;

   modport master (output key, input digit, code, valid, error, busy);
   modport slave  (input key, output digit, code, valid, error, busy);
endinterface

// File: rtl/morse_digit_decoder.sv
// Morse digit decoder: times marks on a keyed line into dots/dashes, collects
// a 5-symbol character and emits the BCD digit plus the raw d5..d1 code.
// Optional build macro MORSE_KEY_SYNC_EN adds a two-flop key synchronizer.
module morse_digit_decoder #(
   parameter int DOT_MAX    = 3,
   parameter int DASH_MAX   = 12,
   parameter int GAP_CYCLES = 8,
   parameter int CNT_W      = 8
) (
   input logic                  clock,
   input logic                  reset,
   morse_digit_decoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
   localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_MAX);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   logic key_s;

`ifdef MORSE_KEY_SYNC_EN
   logic [1:0] key_pipe;
   // Two-flop synchronizer for an asynchronous key line
   always_ff @(posedge clock or posedge reset) begin
      if (reset) key_pipe <= '0;
      else       key_pipe <= {key_pipe[0], bus.key};
   end
   assign key_s = key_pipe[1];
`else
   assign key_s = bus.key;
`endif

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [4:0]       sreg, sreg_nxt;
   logic [2:0]       sym_cnt, sym_cnt_nxt;
   logic             ovf, ovf_nxt, stuck, stuck_nxt;
   logic [3:0]       digit_q, digit_nxt;
   logic [4:0]       code_q, code_nxt;
   logic             valid_q, valid_nxt, error_q, error_nxt;
   logic             tbl_ok;
   logic [3:0]       tbl_digit;
   logic             bad;

   // Code-to-digit lookup of the collected symbols
   always_comb begin
      tbl_ok    = 1'b1;
      tbl_digit = 4'h0;
      case (sreg)
         5'b01111: tbl_digit = 4'd1;
         5'b00111: tbl_digit = 4'd2;
         5'b00011: tbl_digit = 4'd3;
         5'b00001: tbl_digit = 4'd4;
         5'b00000: tbl_digit = 4'd5;
         5'b10000: tbl_digit = 4'd6;
         5'b11000: tbl_digit = 4'd7;
         5'b11100: tbl_digit = 4'd8;
         5'b11110: tbl_digit = 4'd9;
         5'b11111: tbl_digit = 4'd0;
         default:  tbl_ok    = 1'b0;
      endcase
   end

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign bad     = (sym_cnt != 3'd5) || ovf || stuck || !tbl_ok;

   // Next-state logic: mark timing, symbol collection and character emit
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      sreg_nxt    = sreg;
      sym_cnt_nxt = sym_cnt;
      ovf_nxt     = ovf;
      stuck_nxt   = stuck;
      digit_nxt   = digit_q;
      code_nxt    = code_q;
      error_nxt   = error_q;
      valid_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (key_s) begin
               state_nxt   = MARK;
               cnt_nxt     = CNT_W'(1);
               sreg_nxt    = '0;
               sym_cnt_nxt = '0;
               ovf_nxt     = 1'b0;
               stuck_nxt   = 1'b0;
            end
         end
         MARK: begin
            if (key_s) begin
               cnt_nxt = cnt_inc;
               if (cnt_inc > DASH_LIM) stuck_nxt = 1'b1;
            end else begin
               sreg_nxt    = {sreg[3:0], (cnt > DOT_LIM)};
               sym_cnt_nxt = (sym_cnt == 3'd7) ? sym_cnt : sym_cnt + 3'd1;
               if (sym_cnt >= 3'd5) ovf_nxt = 1'b1;
               state_nxt   = SPACE;
               cnt_nxt     = CNT_W'(1);
            end
         end
         SPACE: begin
            if (key_s) begin
               state_nxt = MARK;
               cnt_nxt   = CNT_W'(1);
            end else if (cnt >= GAP_LAST) begin
               // This sample is the final low of the inter-character gap
               state_nxt = IDLE;
               cnt_nxt   = '0;
               valid_nxt = 1'b1;
               code_nxt  = sreg;
               error_nxt = bad;
               digit_nxt = bad ? 4'hF : tbl_digit;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         sreg    <= '0;
         sym_cnt <= '0;
         ovf     <= 1'b0;
         stuck   <= 1'b0;
         digit_q <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         sreg    <= sreg_nxt;
         sym_cnt <= sym_cnt_nxt;
         ovf     <= ovf_nxt;
         stuck   <= stuck_nxt;
         digit_q <= digit_nxt;
         code_q  <= code_nxt;
         valid_q <= valid_nxt;
         error_q <= error_nxt;
      end
   end

   assign bus.digit = digit_q;
   assign bus.code  = code_q;
   assign bus.valid = valid_q;
   assign bus.error = error_q;
   assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_morse_digit_decoder.sv
// Self-checking bench for morse_digit_decoder: vector table of characters,
// encoder-style loopback of digits 0-9, and hand-written timing/reset cases.
module tb_morse_digit_decoder;
   localparam int GAP = 8;
`ifdef MORSE_KEY_SYNC_EN
   localparam int EXP_LAT = GAP + 2;
`else
   localparam int EXP_LAT = GAP;
`endif

   typedef struct {
      logic [4:0] code;
      logic [3:0] digit;
      logic       err;
   } exp_t;

   typedef struct {
      int         n;
      logic [7:0] pat;
      int         dot_len;
      int         dash_len;
      logic [4:0] code;
      logic [3:0] digit;
      logic       err;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   morse_digit_decoder_if bus();

   morse_digit_decoder dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every valid pops one expected character
   always @(negedge clock) begin
      if (!reset && bus.valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: code %b digit %0h (t=%0t)", bus.code, bus.digit, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("code",  32'(bus.code),  32'(e.code));
            chk("digit", 32'(bus.digit), 32'(e.digit));
            chk("error", 32'(bus.error), 32'(e.err));
         end
      end
   end

   task automatic send_mark(input int len);
      bus.key = 1'b1;
      repeat (len) @(negedge clock);
      bus.key = 1'b0;
   endtask

   task automatic space(input int len);
      repeat (len) @(negedge clock);
   endtask

   // Key out n symbols (first symbol = pat[n-1]); expectation queued when the last mark ends
   task automatic send_syms(input int n, input logic [7:0] pat, input int dot_len, input int dash_len,
                            input logic [4:0] ec, input logic [3:0] ed, input logic ee);
      exp_t e;
      for (int i = n - 1; i >= 0; i--) begin
         int len;
         if (pat[i]) len = (dash_len > 0) ? dash_len : int'($urandom_range(4, 12));
         else        len = (dot_len  > 0) ? dot_len  : int'($urandom_range(1, 3));
         send_mark(len);
         if (i > 0) space(int'($urandom_range(1, 6)));
      end
      e.code = ec; e.digit = ed; e.err = ee;
      sb.push_back(e);
   endtask

   initial begin
      vec_t       vecs[9];
      logic [4:0] ones;
      logic [4:0] lc;
      int         k, lat, got;
      logic       busy_prev;

      vecs[0] = '{5, 8'b11000, 2, 6,  5'b11000, 4'd7, 1'b0};
      vecs[1] = '{5, 8'b10000, 3, 4,  5'b10000, 4'd6, 1'b0};
      vecs[2] = '{5, 8'b11110, 1, 12, 5'b11110, 4'd9, 1'b0};
      vecs[3] = '{5, 8'b11111, 1, 13, 5'b11111, 4'hF, 1'b1};
      vecs[4] = '{3, 8'b00000, 2, 6,  5'b00000, 4'hF, 1'b1};
      vecs[5] = '{5, 8'b01011, 0, 0,  5'b01011, 4'hF, 1'b1};
      vecs[6] = '{6, 8'b100000, 0, 0, 5'b00000, 4'hF, 1'b1};
      vecs[7] = '{1, 8'b1, 0, 20,     5'b00001, 4'hF, 1'b1};
      vecs[8] = '{5, 8'b00001, 0, 0,  5'b00001, 4'd4, 1'b0};

      bus.key = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_digit", 32'(bus.digit), 0);
      chk("rst_code",  32'(bus.code),  0);
      chk("rst_valid", 32'(bus.valid), 0);
      chk("rst_error", 32'(bus.error), 0);
      chk("rst_busy",  32'(bus.busy),  0);
      reset = 1'b0;
      space(2);

      // Digit 7 with exact timing: latency and busy around valid
      send_mark(6); space(2); send_mark(6); space(2);
      send_mark(2); space(2); send_mark(2); space(2); send_mark(2);
      begin
         exp_t e;
         e.code = 5'b11000; e.digit = 4'd7; e.err = 1'b0;
         sb.push_back(e);
      end
      lat = 0; got = 0; busy_prev = 1'b0;
      for (int c = 1; c <= 30 && got == 0; c++) begin
         @(negedge clock);
         if (bus.valid) begin
            got = 1;
            lat = c;
            chk("busy_at_valid", 32'(bus.busy), 0);
         end else begin
            busy_prev = bus.busy;
         end
      end
      chk("latency", lat, EXP_LAT);
      chk("busy_before_valid", 32'(busy_prev), 1);
      space(4);

      // Table vectors
      for (int v = 0; v < 9; v++) begin
         send_syms(vecs[v].n, vecs[v].pat, vecs[v].dot_len, vecs[v].dash_len,
                   vecs[v].code, vecs[v].digit, vecs[v].err);
         space(GAP + 4);
      end

      // Back-to-back: digit 1 then digit 0, next mark right after the gap
      send_syms(5, 8'b01111, 0, 0, 5'b01111, 4'd1, 1'b0);
      space(GAP);
      send_syms(5, 8'b11111, 0, 0, 5'b11111, 4'd0, 1'b0);
      space(GAP + 4);

      // Reset mid-character discards the partial symbols
      send_mark(6); space(2); send_mark(2); space(2); send_mark(6); space(2);
      reset = 1'b1;
      #1;
      chk("midrst_busy",  32'(bus.busy),  0);
      chk("midrst_digit", 32'(bus.digit), 0);
      chk("midrst_code",  32'(bus.code),  0);
      chk("midrst_error", 32'(bus.error), 0);
      @(negedge clock);
      reset = 1'b0;
      space(2);
      send_syms(5, 8'b00000, 2, 0, 5'b00000, 4'd5, 1'b0);
      space(GAP + 4);

      // Encoder-style loopback over digits 0-9
      ones = 5'b11111;
      for (int d = 0; d < 10; d++) begin
         if (d >= 1 && d <= 5) lc = ones >> d;
         else begin
            k  = (d == 0) ? 5 : d - 5;
            lc = ones << (5 - k);
         end
         send_syms(5, {3'b000, lc}, 0, 0, lc, 4'(d), 1'b0);
         space(GAP + 4);
      end

      space(GAP + 4);
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
